pixel_stream_packer: RTL and testbench

- Downstream neighbour of the ray-marcher top: consumes its 24-bit shade stream (valid_out/shade_out/sof/eol) and drives its ready_in.
- Buffers pixels in a small FIFO and presents them as an AXI4-Stream video master (tuser = start-of-frame, tlast = end-of-line) to the VDMA / video-out path.
- Absorbs downstream back-pressure so the marcher pipeline stalls cleanly instead of dropping pixels.

---
 rtl/pixel_stream_packer.sv | 156 +++++++++++++++
 tb/tb_pixel_stream_packer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_stream_packer.sv
// Pixel FIFO between the ray-marcher shade stream and an AXI4-Stream video master.
// Optional frame geometry checker enabled by defining FRAME_CHECK_EN.
module pixel_stream_packer #(
  parameter int          DEPTH    = 16,
  parameter int          H_RES    = 640,
  parameter int          V_RES    = 480,
  parameter logic [7:0]  PAD_BYTE = 8'h00
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pix_valid,
  input  logic [23:0]               pix_data,
  input  logic                      pix_sof,
  input  logic                      pix_eol,
  output logic                      pix_ready,
  output logic [31:0]               m_axis_tdata,
  output logic                      m_axis_tuser,
  output logic                      m_axis_tlast,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [$clog2(DEPTH):0]    fifo_level,
  output logic [1:0]                frame_err,
  input  logic                      err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never depends on ready, and a presented output word is held until it transfers.
  logic          push, pop, head_load, mem_rd, mem_wr, bypass;
  logic [25:0]   in_word;
  logic [25:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] mem_cnt_q, mem_cnt_d, level_d;
  logic          head_vld_q, head_vld_d;
  logic [25:0]   head_q, head_d;
  logic          ready_q, ready_d;

  assign in_word = {pix_sof, pix_eol, pix_data};
  assign push    = pix_valid && ready_q;
  assign pop     = head_vld_q && m_axis_tready;

  // The head register is refilled from storage first, or straight from the input when storage is empty.
  always_comb begin
    head_load  = !head_vld_q || pop;
    mem_rd     = head_load && (mem_cnt_q != '0);
    bypass     = head_load && (mem_cnt_q == '0) && push;
    mem_wr     = push && !bypass;
    head_vld_d = head_vld_q;
    head_d     = head_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (head_load) begin
      head_vld_d = mem_rd || bypass;
      if (mem_rd) begin
        head_d = mem[rd_ptr_q];
      end else if (bypass) begin
        head_d = in_word;
      end
    end
    if (mem_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    if (mem_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    mem_cnt_d = mem_cnt_q + LW'(mem_wr) - LW'(mem_rd);
    level_d   = mem_cnt_d + LW'(head_vld_d);
    ready_d   = level_d < DEPTH_L;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_cnt_q  <= '0;
      head_vld_q <= 1'b0;
      head_q     <= '0;
      ready_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mem_cnt_q  <= mem_cnt_d;
      head_vld_q <= head_vld_d;
      head_q     <= head_d;
      ready_q    <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_wr) mem[wr_ptr_q] <= in_word;
  end

  assign pix_ready     = ready_q;
  assign m_axis_tvalid = head_vld_q;
  assign m_axis_tuser  = head_q[25];
  assign m_axis_tlast  = head_q[24];
  assign m_axis_tdata  = {PAD_BYTE, head_q[23:0]};
  assign fifo_level    = mem_cnt_q + LW'(head_vld_q);

`ifdef FRAME_CHECK_EN
  localparam int XW = $clog2(H_RES + 1);
  localparam int YW = $clog2(V_RES + 1);
  localparam logic [XW-1:0] H_LAST = XW'(H_RES - 1);
  localparam logic [YW-1:0] V_LAST = YW'(V_RES - 1);

  logic [XW-1:0] x_cnt_q, x_cnt_d, eff_x;
  logic [YW-1:0] y_cnt_q, y_cnt_d, eff_y;
  logic          seen_sof_q, seen_sof_d, at_origin;
  logic [1:0]    err_q, err_d;

  // A sof pixel is judged as position (0,0); a missing eol still closes the line at H_RES.
  always_comb begin
    x_cnt_d    = x_cnt_q;
    y_cnt_d    = y_cnt_q;
    seen_sof_d = seen_sof_q;
    err_d      = err_clr ? 2'b00 : err_q;
    at_origin  = (x_cnt_q == '0) && (y_cnt_q == '0);
    eff_x      = pix_sof ? '0 : x_cnt_q;
    eff_y      = pix_sof ? '0 : y_cnt_q;
    if (push) begin
      if (pix_sof && !at_origin) err_d[0] = 1'b1;
      if (!pix_sof && at_origin && seen_sof_q) err_d[0] = 1'b1;
      if (pix_eol != (eff_x == H_LAST)) err_d[1] = 1'b1;
      if (pix_sof) seen_sof_d = 1'b1;
      if (pix_eol || (eff_x == H_LAST)) begin
        x_cnt_d = '0;
        y_cnt_d = (eff_y == V_LAST) ? '0 : eff_y + YW'(1);
      end else begin
        x_cnt_d = eff_x + XW'(1);
        y_cnt_d = eff_y;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_cnt_q    <= '0;
      y_cnt_q    <= '0;
      seen_sof_q <= 1'b0;
      err_q      <= 2'b00;
    end else begin
      x_cnt_q    <= x_cnt_d;
      y_cnt_q    <= y_cnt_d;
      seen_sof_q <= seen_sof_d;
      err_q      <= err_d;
    end
  end

  assign frame_err = err_q;
`else
  localparam int unused_frame_px = H_RES * V_RES;
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign frame_err      = 2'b00;
`endif

endmodule

// File: tb/tb_pixel_stream_packer.sv
// Bench for pixel_stream_packer: a queue model of the accepted pixels is checked against
// the AXI output every cycle, plus literal checks of latency, capacity, reset and frame errors.
module tb_pixel_stream_packer;
  localparam int         DEPTH = 16;
  localparam int         H_RES = 640;
  localparam int         V_RES = 4;
  localparam logic [7:0] PAD   = 8'h00;
  localparam int         LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          pix_valid = 1'b0;
  logic [23:0]   pix_data = '0;
  logic          pix_sof = 1'b0;
  logic          pix_eol = 1'b0;
  logic          pix_ready;
  logic [31:0]   m_axis_tdata;
  logic          m_axis_tuser, m_axis_tlast, m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic [LW-1:0] fifo_level;
  logic [1:0]    frame_err;
  logic          err_clr = 1'b0;

  pixel_stream_packer #(
    .DEPTH(DEPTH), .H_RES(H_RES), .V_RES(V_RES), .PAD_BYTE(PAD)
  ) dut (
    .clk(clk), .rst(rst),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_sof(pix_sof), .pix_eol(pix_eol),
    .pix_ready(pix_ready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .fifo_level(fifo_level), .frame_err(frame_err), .err_clr(err_clr)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  bit post_rst = 1'b0;
  always @(posedge clk or negedge rst) begin
    if (!rst) post_rst <= 1'b0;
    else      post_rst <= 1'b1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [25:0] exp_q[$];
  bit          prev_hold = 1'b0;
  logic [33:0] prev_out = '0;
  int          pop_cnt = 0;
  int          tlast_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      prev_hold = 1'b0;
      check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
      check("rst_level", 64'(fifo_level), 64'd0);
      check("rst_ready", 64'(pix_ready), 64'd0);
      check("rst_tdata", 64'({m_axis_tuser, m_axis_tlast, m_axis_tdata}), 64'd0);
    end else begin
      check("level", 64'(fifo_level), 64'(exp_q.size()));
      check("tvalid", 64'(m_axis_tvalid), 64'(exp_q.size() > 0));
      if (post_rst) check("pix_ready", 64'(pix_ready), 64'(exp_q.size() < DEPTH));
      else          check("pix_ready_first", 64'(pix_ready), 64'd0);
      if (exp_q.size() > 0)
        check("head", 64'({m_axis_tuser, m_axis_tlast, m_axis_tdata}),
              64'({exp_q[0][25], exp_q[0][24], PAD, exp_q[0][23:0]}));
      if (prev_hold)
        check("stable", 64'({m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata}),
              64'({1'b1, prev_out}));
`ifndef FRAME_CHECK_EN
      check("frame_err_off", 64'(frame_err), 64'd0);
`endif
      prev_hold = m_axis_tvalid && !m_axis_tready;
      prev_out  = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
      if (m_axis_tvalid && m_axis_tready && exp_q.size() > 0) begin
        pop_cnt++;
        if (m_axis_tlast) tlast_cnt++;
        void'(exp_q.pop_front());
      end
      if (pix_valid && pix_ready) exp_q.push_back({pix_sof, pix_eol, pix_data});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    pix_valid = 1'b0;
    m_axis_tready = 1'b0;
    err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    tick();
  endtask

  // Pushes n pixels; sof on the first when frame_sof, eol every hres pixels.
  task automatic stream(input int n, input int hres, input bit frame_sof,
                        input int vpct, input int rpct, output int cycles);
    int  idx;
    bit  acc;
    idx = 0;
    cycles = 0;
    pix_data = 24'($urandom());
    while (idx < n && cycles < 20000) begin
      pix_valid     = ($urandom_range(99) < vpct);
      pix_sof       = frame_sof && (idx == 0);
      pix_eol       = ((idx % hres) == hres - 1);
      m_axis_tready = ($urandom_range(99) < rpct);
      @(negedge clk);
      acc = pix_valid && pix_ready;
      tick();
      cycles++;
      if (acc) begin
        idx++;
        pix_data = 24'($urandom());
      end
    end
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    pix_eol   = 1'b0;
    if (idx < n) check("stream_timeout", 64'(idx), 64'(n));
  endtask

  task automatic drain(input int rpct);
    int cyc;
    cyc = 0;
    pix_valid = 1'b0;
    while (exp_q.size() > 0 && cyc < 5000) begin
      m_axis_tready = ($urandom_range(99) < rpct);
      tick();
      cyc++;
    end
    m_axis_tready = 1'b0;
    tick();
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  int cyc, acc_cnt, p0, t0;

  initial begin
    do_reset();
    check("ready_after_rst", 64'(pix_ready), 64'd1);

    // Single pixel latency
    pix_valid = 1'b1; pix_data = 24'hABCDEF; pix_sof = 1'b1; pix_eol = 1'b0;
    m_axis_tready = 1'b1;
    tick();
    pix_valid = 1'b0; pix_sof = 1'b0;
    check("lat_tvalid", 64'(m_axis_tvalid), 64'd1);
    check("lat_tdata", 64'(m_axis_tdata), 64'h00ABCDEF);
    check("lat_tuser", 64'(m_axis_tuser), 64'd1);
    check("lat_level", 64'(fifo_level), 64'd1);
    tick();
    check("pop_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("pop_level", 64'(fifo_level), 64'd0);

    // Fill against a stalled sink
    m_axis_tready = 1'b0; pix_valid = 1'b1; acc_cnt = 0;
    repeat (20) begin
      pix_data = 24'($urandom());
      @(negedge clk);
      if (pix_valid && pix_ready) acc_cnt++;
      tick();
    end
    pix_valid = 1'b0;
    check("fill_count", 64'(acc_cnt), 64'd16);
    check("fill_ready", 64'(pix_ready), 64'd0);
    check("fill_level", 64'(fifo_level), 64'd16);
    m_axis_tready = 1'b1;
    tick();
    check("reopen_ready", 64'(pix_ready), 64'd1);
    check("reopen_level", 64'(fifo_level), 64'd15);
    drain(100);

    // One full line at full rate
    p0 = pop_cnt; t0 = tlast_cnt;
    stream(H_RES, H_RES, 1'b1, 100, 100, cyc);
    check("line_cycles", 64'(cyc), 64'(H_RES));
    drain(100);
    check("line_pops", 64'(pop_cnt - p0), 64'(H_RES));
    check("line_tlast", 64'(tlast_cnt - t0), 64'd1);

    // Random mix with short lines and a mostly stalled sink
    stream(300, 37, 1'b0, 90, 30, cyc);
    drain(60);

    // Random full frame
    do_reset();
    stream(H_RES * V_RES, H_RES, 1'b1, 70, 50, cyc);
    drain(50);
`ifdef FRAME_CHECK_EN
    check("frame_clean", 64'(frame_err), 64'd0);

    // Short line: eol at x=638
    stream(H_RES - 1, H_RES - 1, 1'b1, 100, 100, cyc);
    drain(100);
    check("short_line", 64'(frame_err), 64'h2);
    repeat (3) tick();
    check("short_line_sticky", 64'(frame_err), 64'h2);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_clr", 64'(frame_err), 64'h0);

    // Sof in the middle of a line
    stream(5, H_RES, 1'b0, 100, 100, cyc);
    stream(1, H_RES, 1'b1, 100, 100, cyc);
    drain(100);
    check("mid_sof", 64'(frame_err), 64'h1);
`endif

    // Asynchronous reset with 7 pixels buffered
    stream(7, H_RES, 1'b0, 100, 0, cyc);
    check("pre_rst_level", 64'(fifo_level), 64'd7);
    #2 rst = 1'b0;
    #1;
    check("async_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("async_level", 64'(fifo_level), 64'd0);
    check("async_frame_err", 64'(frame_err), 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    tick();
    pix_valid = 1'b1; pix_data = 24'h123456; pix_sof = 1'b0; pix_eol = 1'b0;
    m_axis_tready = 1'b1;
    tick();
    pix_valid = 1'b0;
    check("post_rst_tvalid", 64'(m_axis_tvalid), 64'd1);
    check("post_rst_tdata", 64'(m_axis_tdata), 64'h00123456);
    drain(100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
